// File: rtl/dmem_arbiter_if.sv
// Bundle of core request/ack signals and the memory command port shared by
// the data-memory arbiter and whatever sits around it.
interface dmem_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
);
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES-1:0]        core_ack;
  logic [NUM_CORES-1:0]        core_err;
  logic [DATA_W-1:0]           core_rdata;
  logic [1:0]                  mem_control;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        busy;

  // Arbiter view: serves the cores and drives the memory command port.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata, mem_rdata,
    output core_ack, core_err, core_rdata, mem_control, mem_addr, mem_wdata, busy
  );

  // Environment view: the cores plus the memory itself.
  modport master (
    output core_req, core_we, core_addr, core_wdata, mem_rdata,
    input  core_ack, core_err, core_rdata, mem_control, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among several cores.
// Each grant walks IDLE -> ACCESS -> RESP and returns a one-cycle ack (and err).
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  dmem_arbiter_if.slave bus
);
  localparam int CW = $clog2(NUM_CORES);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cur_reg, cur_next;
  logic [CW-1:0]        last_reg, last_next;
  logic                 oor_reg, oor_next;
  logic                 we_reg, we_next;
  logic [1:0]           mem_control_reg, mem_control_next;
  logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]    mem_wdata_reg, mem_wdata_next;
  logic [NUM_CORES-1:0] core_ack_reg, core_ack_next;
  logic [NUM_CORES-1:0] core_err_reg, core_err_next;
  logic [DATA_W-1:0]    core_rdata_reg, core_rdata_next;

  logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    wdata_arr [NUM_CORES];
  logic [NUM_CORES-1:0] oor_vec;
  logic [NUM_CORES-1:0] eligible;
  logic                 grant_valid;
  logic [CW-1:0]        grant_idx;
  logic [CW:0]          search_idx;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.core_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.core_wdata[gi*DATA_W +: DATA_W];
      assign oor_vec[gi]   = ({1'b0, addr_arr[gi]} >= DEPTH_EXT);
    end
  endgenerate

  // A core whose ack is on the bus this cycle may still hold req; skip it.
  assign eligible = bus.core_req & ~core_ack_reg;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      search_idx = {1'b0, last_reg} + (CW+1)'(k);
      if (search_idx >= (CW+1)'(NUM_CORES)) begin
        search_idx = search_idx - (CW+1)'(NUM_CORES);
      end
      if (!grant_valid && eligible[search_idx[CW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx[CW-1:0];
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    cur_next         = cur_reg;
    last_next        = last_reg;
    oor_next         = oor_reg;
    we_next          = we_reg;
    mem_control_next = mem_control_reg;
    mem_addr_next    = mem_addr_reg;
    mem_wdata_next   = mem_wdata_reg;
    core_ack_next    = '0;
    core_err_next    = '0;
    core_rdata_next  = core_rdata_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next     = ACCESS;
          cur_next       = grant_idx;
          last_next      = grant_idx;
          we_next        = bus.core_we[grant_idx];
          oor_next       = oor_vec[grant_idx];
          mem_addr_next  = addr_arr[grant_idx];
          mem_wdata_next = wdata_arr[grant_idx];
          if (oor_vec[grant_idx]) begin
            mem_control_next = CMD_IDLE;
          end else if (bus.core_we[grant_idx]) begin
            mem_control_next = CMD_WRITE;
          end else begin
            mem_control_next = CMD_READ;
          end
        end
      end
      ACCESS: begin
        mem_control_next = CMD_IDLE;
        state_next       = RESP;
      end
      RESP: begin
        core_rdata_next         = (!oor_reg && !we_reg) ? bus.mem_rdata : '0;
        core_ack_next[cur_reg]  = 1'b1;
        core_err_next[cur_reg]  = oor_reg;
        state_next              = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cur_reg         <= '0;
      last_reg        <= CW'(NUM_CORES - 1);
      oor_reg         <= 1'b0;
      we_reg          <= 1'b0;
      mem_control_reg <= CMD_IDLE;
      mem_addr_reg    <= '0;
      mem_wdata_reg   <= '0;
      core_ack_reg    <= '0;
      core_err_reg    <= '0;
      core_rdata_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      cur_reg         <= cur_next;
      last_reg        <= last_next;
      oor_reg         <= oor_next;
      we_reg          <= we_next;
      mem_control_reg <= mem_control_next;
      mem_addr_reg    <= mem_addr_next;
      mem_wdata_reg   <= mem_wdata_next;
      core_ack_reg    <= core_ack_next;
      core_err_reg    <= core_err_next;
      core_rdata_reg  <= core_rdata_next;
    end
  end

  assign bus.core_ack    = core_ack_reg;
  assign bus.core_err    = core_err_reg;
  assign bus.core_rdata  = core_rdata_reg;
  assign bus.mem_control = mem_control_reg;
  assign bus.mem_addr    = mem_addr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.busy        = (state_reg != IDLE);
endmodule
